sipo_deserializer: RTL and testbench

- Serial-in/parallel-out front end that assembles a WIDTH-bit word from a qualified serial bit stream.
- Presents the word on a valid/ready parallel port that feeds the downstream parallel-in/parallel-out holding register (pa..pd side).
- Keeps shifting while the completed word waits in an output buffer; flags overflow and aborted frames.

---
 rtl/sipo_deserializer.sv | 151 +++++++++++++++
 tb/tb_sipo_deserializer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer with a one-word valid/ready output buffer.
// Optional even-parity bit after each word when SIPO_PARITY_CHECK_EN is defined.
module sipo_deserializer #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             sin_start,
    output logic [WIDTH-1:0] pout,
    output logic             pout_valid,
    input  logic             pout_ready,
    output logic             busy,
    output logic             overflow,
    output logic             frame_abort,
    output logic             parity_err
);

    localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int unsigned POS0  = (MSB_FIRST != 0) ? (WIDTH - 1) : 0;

`ifdef SIPO_PARITY_CHECK_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
`endif

    state_t             state_q, state_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic [WIDTH-1:0]   sr_q, sr_n;
    logic [WIDTH-1:0]   pout_n;
    logic               valid_n, ovf_n, abort_n, perr_n, busy_n;
    logic               done;
    logic [WIDTH-1:0]   commit_word;
    int unsigned        bit_pos;
    logic [WIDTH-1:0]   word_c;
    logic [WIDTH-1:0]   start_word_c;
    logic               last_c;

    // Place the incoming bit at the slot selected by the running bit count.
    assign bit_pos      = (MSB_FIRST != 0) ? (WIDTH - 1 - 32'(cnt_q)) : 32'(cnt_q);
    assign word_c       = sr_q | (WIDTH'(sin) << bit_pos);
    assign start_word_c = WIDTH'(sin) << POS0;
    assign last_c       = (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sr_q        <= '0;
            pout        <= '0;
            pout_valid  <= 1'b0;
            busy        <= 1'b0;
            overflow    <= 1'b0;
            frame_abort <= 1'b0;
            parity_err  <= 1'b0;
        end else begin
            state_q     <= state_n;
            cnt_q       <= cnt_n;
            sr_q        <= sr_n;
            pout        <= pout_n;
            pout_valid  <= valid_n;
            busy        <= busy_n;
            overflow    <= ovf_n;
            frame_abort <= abort_n;
            parity_err  <= perr_n;
        end
    end

    always_comb begin
        state_n     = state_q;
        cnt_n       = cnt_q;
        sr_n        = sr_q;
        done        = 1'b0;
        commit_word = sr_q;
        abort_n     = 1'b0;
        perr_n      = 1'b0;
        pout_n      = pout;
        valid_n     = pout_valid;
        ovf_n       = overflow;

        case (state_q)
            IDLE: begin
                if (sin_valid && sin_start) begin
                    sr_n    = start_word_c;
                    cnt_n   = CNT_W'(1);
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (sin_valid) begin
                    if (sin_start) begin
                        abort_n = 1'b1;
                        sr_n    = start_word_c;
                        cnt_n   = CNT_W'(1);
                    end else if (last_c) begin
                        cnt_n = '0;
`ifdef SIPO_PARITY_CHECK_EN
                        sr_n    = word_c;
                        state_n = PAR;
`else
                        sr_n        = '0;
                        state_n     = IDLE;
                        done        = 1'b1;
                        commit_word = word_c;
`endif
                    end else begin
                        sr_n  = word_c;
                        cnt_n = cnt_q + CNT_W'(1);
                    end
                end
            end
`ifdef SIPO_PARITY_CHECK_EN
            PAR: begin
                if (sin_valid) begin
                    if (sin_start) begin
                        abort_n = 1'b1;
                        sr_n    = start_word_c;
                        cnt_n   = CNT_W'(1);
                        state_n = SHIFT;
                    end else begin
                        state_n     = IDLE;
                        sr_n        = '0;
                        commit_word = sr_q;
                        if (^{sr_q, sin}) perr_n = 1'b1;
                        else              done   = 1'b1;
                    end
                end
            end
`endif
            default: state_n = IDLE;
        endcase

        // Output buffer: a completed word replaces, fills, or overflows.
        if (done) begin
            if (!pout_valid || pout_ready) begin
                pout_n  = commit_word;
                valid_n = 1'b1;
            end else begin
                ovf_n = 1'b1;
            end
        end else if (pout_valid && pout_ready) begin
            valid_n = 1'b0;
        end

        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Self-checking bench for sipo_deserializer (WIDTH=4, MSB_FIRST=1): vector table,
// hand sequences, and randomized traffic against a queue-based reference model.
module tb_sipo_deserializer;

    localparam int unsigned W   = 4;
    localparam int unsigned MSB = 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         sin, sin_valid, sin_start, pout_ready;
    logic [W-1:0] pout;
    logic         pout_valid, busy, overflow, frame_abort, parity_err;

    int n_checks = 0;
    int n_pass   = 0;

    sipo_deserializer #(.WIDTH(W), .MSB_FIRST(MSB)) dut (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .sin_start(sin_start),
        .pout(pout), .pout_valid(pout_valid), .pout_ready(pout_ready), .busy(busy),
        .overflow(overflow), .frame_abort(frame_abort), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         r, v, s, st, rdy;
        logic [W-1:0] e_pout;
        logic         e_val, e_busy, e_ovf, e_abort;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    endtask

    task automatic chk_all(input string tag, input logic [W-1:0] ep, input logic ev,
                           input logic eb, input logic eo, input logic ea, input logic ee);
        chk({tag, ".pout"},        32'(pout),        32'(ep));
        chk({tag, ".pout_valid"},  32'(pout_valid),  32'(ev));
        chk({tag, ".busy"},        32'(busy),        32'(eb));
        chk({tag, ".overflow"},    32'(overflow),    32'(eo));
        chk({tag, ".frame_abort"}, 32'(frame_abort), 32'(ea));
        chk({tag, ".parity_err"},  32'(parity_err),  32'(ee));
    endtask

    // Drive inputs on the falling edge, let one rising edge pass, return on the next falling edge.
    task automatic drive(input logic r, input logic v, input logic s, input logic st, input logic rdy);
        rst = r; sin_valid = v; sin = s; sin_start = st; pout_ready = rdy;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference model: collects bits in a queue and applies the buffer rules directly.
    logic [W-1:0] m_pout;
    bit m_valid, m_ovf, m_abort, m_perr, m_in_frame, m_par_wait;
    bit m_bits[$];

    task automatic model_reset();
        m_pout = '0; m_valid = 0; m_ovf = 0; m_abort = 0; m_perr = 0;
        m_in_frame = 0; m_par_wait = 0; m_bits.delete();
    endtask

    task automatic model_step(input bit v, input bit s, input bit st, input bit rdy);
        bit done, ok, x;
        logic [W-1:0] w;
        done = 0; ok = 1; m_abort = 0; m_perr = 0; w = '0;
        if (v) begin
            if (st) begin
                if (m_in_frame) m_abort = 1;
                m_bits.delete();
                m_bits.push_back(s);
                m_in_frame = 1;
                m_par_wait = 0;
            end else if (m_in_frame) begin
                if (m_par_wait) begin
                    x = s;
                    foreach (m_bits[k]) x ^= m_bits[k];
                    ok = (x == 0);
                    done = 1;
                end else begin
                    m_bits.push_back(s);
                    if (m_bits.size() == W) begin
`ifdef SIPO_PARITY_CHECK_EN
                        m_par_wait = 1;
`else
                        done = 1;
`endif
                    end
                end
            end
        end
        if (done) begin
            for (int k = 0; k < W; k++) begin
                if (MSB != 0) w[W-1-k] = m_bits[k];
                else          w[k]     = m_bits[k];
            end
            m_in_frame = 0; m_par_wait = 0; m_bits.delete();
            if (!ok) m_perr = 1;
        end
        if (done && ok) begin
            if (!m_valid)  begin m_pout = w; m_valid = 1; end
            else if (rdy)  m_pout = w;
            else           m_ovf = 1;
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
    endtask

    vec_t tbl[$];

    task automatic add(input logic r, input logic v, input logic s, input logic st, input logic rdy,
                       input logic [W-1:0] ep, input logic ev, input logic eb, input logic eo,
                       input logic ea);
        vec_t t;
        t.r = r; t.v = v; t.s = s; t.st = st; t.rdy = rdy;
        t.e_pout = ep; t.e_val = ev; t.e_busy = eb; t.e_ovf = eo; t.e_abort = ea;
        tbl.push_back(t);
    endtask

    task automatic send_word(input logic [W-1:0] data, input int gap, input logic rdy);
        for (int k = 0; k < W; k++) begin
            drive(1, 1, data[W-1-k], (k == 0), rdy);
            for (int g = 0; g < gap && k < W - 1; g++) drive(1, 0, 0, 0, rdy);
        end
    endtask

    initial begin
        rst = 1'b0; sin = 0; sin_valid = 0; sin_start = 0; pout_ready = 0;
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        chk_all("reset", '0, 0, 0, 0, 0, 0);

`ifndef SIPO_PARITY_CHECK_EN
        // Basic frame, buffered overflow, replace-on-ready, abort, idle bits ignored.
        add(1,1,1,1,0, 4'b0000,0,1,0,0); add(1,1,0,0,0, 4'b0000,0,1,0,0);
        add(1,1,1,0,0, 4'b0000,0,1,0,0); add(1,1,1,0,0, 4'b1011,1,0,0,0);
        add(1,0,0,0,1, 4'b1011,0,0,0,0);
        add(1,1,0,1,0, 4'b1011,0,1,0,0); add(1,1,1,0,0, 4'b1011,0,1,0,0);
        add(1,1,0,0,0, 4'b1011,0,1,0,0); add(1,1,1,0,0, 4'b0101,1,0,0,0);
        add(1,1,1,1,0, 4'b0101,1,1,0,0); add(1,1,1,0,0, 4'b0101,1,1,0,0);
        add(1,1,1,0,0, 4'b0101,1,1,0,0); add(1,1,1,0,0, 4'b0101,1,0,1,0);
        add(1,0,0,0,0, 4'b0101,1,0,1,0); add(1,0,0,0,1, 4'b0101,0,0,1,0);
        add(0,0,0,0,0, 4'b0000,0,0,0,0);
        add(1,1,0,1,0, 4'b0000,0,1,0,0); add(1,1,0,0,0, 4'b0000,0,1,0,0);
        add(1,1,0,0,0, 4'b0000,0,1,0,0); add(1,1,1,0,0, 4'b0001,1,0,0,0);
        add(1,1,0,1,0, 4'b0001,1,1,0,0); add(1,1,1,0,0, 4'b0001,1,1,0,0);
        add(1,1,1,0,0, 4'b0001,1,1,0,0); add(1,1,0,0,1, 4'b0110,1,0,0,0);
        add(1,0,0,0,1, 4'b0110,0,0,0,0);
        add(1,1,1,1,0, 4'b0110,0,1,0,0); add(1,1,1,0,0, 4'b0110,0,1,0,0);
        add(1,1,1,1,0, 4'b0110,0,1,0,1); add(1,1,0,0,0, 4'b0110,0,1,0,0);
        add(1,1,0,0,0, 4'b0110,0,1,0,0); add(1,1,1,0,0, 4'b1001,1,0,0,0);
        add(1,0,0,0,1, 4'b1001,0,0,0,0);
        add(1,1,1,0,0, 4'b1001,0,0,0,0);
        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].v, tbl[i].s, tbl[i].st, tbl[i].rdy);
            chk_all($sformatf("vec%0d", i), tbl[i].e_pout, tbl[i].e_val, tbl[i].e_busy,
                    tbl[i].e_ovf, tbl[i].e_abort, 1'b0);
        end

        // Gapped frame, then overflow, then asynchronous reset mid-frame.
        drive(0, 0, 0, 0, 0);
        send_word(4'b0111, 3, 0);
        chk_all("gap", 4'b0111, 1, 0, 0, 0, 0);
        send_word(4'b1111, 0, 0);
        chk_all("gap_ovf", 4'b0111, 1, 0, 1, 0, 0);
        drive(1, 1, 1, 1, 0);
        drive(1, 1, 0, 0, 0);
        chk_all("midframe", 4'b0111, 1, 1, 1, 0, 0);
        rst = 1'b0;
        #1;
        chk_all("async_rst", '0, 0, 0, 0, 0, 0);
        @(negedge clk);
`else
        // Parity match commits; parity mismatch pulses parity_err and drops the word.
        send_word(4'b1011, 0, 0);
        chk_all("par_wait", '0, 0, 1, 0, 0, 0);
        drive(1, 1, 1, 0, 0);
        chk_all("par_ok", 4'b1011, 1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 1);
        chk_all("par_consume", 4'b1011, 0, 0, 0, 0, 0);
        send_word(4'b1011, 0, 0);
        drive(1, 1, 0, 0, 0);
        chk_all("par_bad", 4'b1011, 0, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0);
        chk_all("par_pulse_end", 4'b1011, 0, 0, 0, 0, 0);
`endif

        // Randomized traffic against the reference model.
        for (int seg = 0; seg < 3; seg++) begin
            drive(0, 0, 0, 0, 0);
            model_reset();
            for (int c = 0; c < 400; c++) begin
                bit v, s, st, rdy;
                v   = ($urandom_range(0, 3) != 0);
                s   = 1'($urandom_range(0, 1));
                st  = ($urandom_range(0, 5) == 0);
                rdy = ($urandom_range(0, 2) == 0);
                model_step(v, s, st, rdy);
                drive(1, v, s, st, rdy);
                chk_all($sformatf("rnd%0d_%0d", seg, c), m_pout, m_valid, m_in_frame,
                        m_ovf, m_abort, m_perr);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
